// File: rtl/gb_bus_pkg.sv
// Shared definitions for the GB cartridge bus master: op codes, mapper register
// addresses, SRAM window bounds and the payload types passed between blocks.
package gb_bus_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned REQ_ADDR_W = 23;
    localparam int unsigned OFFS_W     = 14;
    localparam int unsigned BANK_W     = REQ_ADDR_W - OFFS_W;

    typedef enum logic [1:0] {
        OP_RAW_RD = 2'b00,
        OP_RAW_WR = 2'b01,
        OP_LIN_RD = 2'b10,
        OP_RSVD   = 2'b11
    } gb_op_e;

    localparam logic [ADDR_W-1:0] GB_REG_ROMB_LO = 16'h2000;
    localparam logic [ADDR_W-1:0] GB_REG_ROMB_HI = 16'h3000;
    localparam logic [ADDR_W-1:0] GB_ROMX_BASE   = 16'h4000;
    localparam logic [ADDR_W-1:0] GB_SRAM_LO     = 16'hA000;
    localparam logic [ADDR_W-1:0] GB_SRAM_HI     = 16'hBFFF;

    // One bus cycle request handed to the cycle engine
    typedef struct packed {
        logic              is_write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } gb_cyc_req_t;

    // Last bank number written to the mapper, split as the mapper stores it
    typedef struct packed {
        logic [7:0] lo;
        logic       lo_valid;
        logic       hi;
        logic       hi_valid;
    } gb_bank_cache_t;

    function automatic logic in_sram(input logic [ADDR_W-1:0] a);
        return (a >= GB_SRAM_LO) && (a <= GB_SRAM_HI);
    endfunction

    function automatic logic [ADDR_W-1:0] romx_addr(input logic [OFFS_W-1:0] offs);
        return GB_ROMX_BASE | ADDR_W'(offs);
    endfunction

    function automatic gb_cyc_req_t mk_req(input logic w, input logic [ADDR_W-1:0] a,
                                           input logic [DATA_W-1:0] d);
        gb_cyc_req_t r;
        r.is_write = w;
        r.addr     = a;
        r.wdata    = d;
        return r;
    endfunction

endpackage

// File: rtl/gb_bus_cycle.sv
// One-shot GB bus cycle engine: SETUP -> STROBE -> HOLD with registered pins.
// A start in the last HOLD clock chains the next cycle with no idle gap.
module gb_bus_cycle
    import gb_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  gb_cyc_req_t       req_i,
    input  logic [DATA_W-1:0] gb_din_i,
    output logic [ADDR_W-1:0] gb_addr_o,
    output logic [DATA_W-1:0] gb_dout_o,
    output logic              gb_doe_o,
    output logic              gb_rd_n_o,
    output logic              gb_wr_n_o,
    output logic              gb_cs_n_o,
    output logic              done_o,
    output logic              last_c_o,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD} phase_e;

    phase_e            phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    gb_cyc_req_t       req_q, req_d;
    logic              doe_q, doe_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic              cs_n_q, cs_n_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            doe_q   <= 1'b0;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            doe_q   <= doe_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
            cs_n_q  <= cs_n_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        doe_d   = doe_q;
        rd_n_d  = rd_n_q;
        wr_n_d  = wr_n_q;
        cs_n_d  = cs_n_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;

        case (phase_q)
            PH_SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    phase_d = PH_STROBE;
                    cnt_d   = '0;
                    rd_n_d  = req_q.is_write;
                    wr_n_d  = !req_q.is_write;
                    cs_n_d  = !in_sram(req_q.addr);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PH_STROBE: begin
                // Read data is taken on the edge that ends the strobe
                if (cnt_q == CNT_W'(STROBE_CYC - 1)) begin
                    phase_d = PH_HOLD;
                    cnt_d   = '0;
                    rd_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                    if (!req_q.is_write) begin
                        rdata_d = gb_din_i;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PH_HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                    phase_d = PH_IDLE;
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    doe_d   = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase

        if (start_i) begin
            phase_d = PH_SETUP;
            cnt_d   = '0;
            req_d   = req_i;
            doe_d   = req_i.is_write;
            rd_n_d  = 1'b1;
            wr_n_d  = 1'b1;
            cs_n_d  = 1'b1;
            done_d  = 1'b0;
        end
    end

    assign last_c_o  = (phase_q == PH_HOLD) && (cnt_q == CNT_W'(HOLD_CYC - 1));
    assign gb_addr_o = req_q.addr;
    assign gb_dout_o = req_q.wdata;
    assign gb_doe_o  = doe_q;
    assign gb_rd_n_o = rd_n_q;
    assign gb_wr_n_o = wr_n_q;
    assign gb_cs_n_o = cs_n_q;
    assign done_o    = done_q;
    assign rdata_o   = rdata_q;

endmodule

// File: rtl/gb_cart_bus_master.sv
// Console-side GB cartridge bus master for MBC5-class mappers: raw reads/writes
// and linear ROM reads that insert bank-select writes only when the bank changes.
module gb_cart_bus_master
    import gb_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [REQ_ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_W-1:0]     rsp_data_o,
    output logic [ADDR_W-1:0]     gb_addr_o,
    output logic [DATA_W-1:0]     gb_dout_o,
    output logic                  gb_doe_o,
    input  logic [DATA_W-1:0]     gb_din_i,
    output logic                  gb_rd_n_o,
    output logic                  gb_wr_n_o,
    output logic                  gb_cs_n_o
);

    typedef enum logic [2:0] {ST_IDLE, ST_WR_LO, ST_WR_HI, ST_RD, ST_DONE} state_e;

    state_e                state_q, state_d;
    logic                  lin_q, lin_d;
    logic                  wr_q, wr_d;
    logic [REQ_ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    gb_bank_cache_t        cache_q, cache_d;
    logic                  ready_q, ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;

    logic                  start_c;
    gb_cyc_req_t           cyc_req_c;
    logic                  cyc_done;
    logic                  cyc_last_c;
    logic [DATA_W-1:0]     cyc_rdata;

    logic [BANK_W-1:0]     bank_in_c, bank_q_c;
    logic                  need_lo_in_c, need_hi_in_c, need_hi_q_c;

    assign bank_in_c    = req_addr_i[REQ_ADDR_W-1:OFFS_W];
    assign bank_q_c     = addr_q[REQ_ADDR_W-1:OFFS_W];
    assign need_lo_in_c = !cache_q.lo_valid || (cache_q.lo != bank_in_c[7:0]);
    assign need_hi_in_c = !cache_q.hi_valid || (cache_q.hi != bank_in_c[8]);
    assign need_hi_q_c  = !cache_q.hi_valid || (cache_q.hi != bank_q_c[8]);

    gb_bus_cycle #(
        .SETUP_CYC  (SETUP_CYC),
        .STROBE_CYC (STROBE_CYC),
        .HOLD_CYC   (HOLD_CYC)
    ) u_cycle (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_c),
        .req_i     (cyc_req_c),
        .gb_din_i  (gb_din_i),
        .gb_addr_o (gb_addr_o),
        .gb_dout_o (gb_dout_o),
        .gb_doe_o  (gb_doe_o),
        .gb_rd_n_o (gb_rd_n_o),
        .gb_wr_n_o (gb_wr_n_o),
        .gb_cs_n_o (gb_cs_n_o),
        .done_o    (cyc_done),
        .last_c_o  (cyc_last_c),
        .rdata_o   (cyc_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            lin_q       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cache_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            lin_q       <= lin_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cache_q     <= cache_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Command sequencing; each bank/access cycle is launched in the last HOLD clock of the previous one
    always_comb begin
        state_d     = state_q;
        lin_d       = lin_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cache_d     = cache_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        start_c     = 1'b0;
        cyc_req_c   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    lin_d   = (gb_op_e'(req_op_i) == OP_LIN_RD);
                    wr_d    = (gb_op_e'(req_op_i) == OP_RAW_WR);
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    start_c = 1'b1;
                    if (lin_d) begin
                        if (need_lo_in_c) begin
                            state_d   = ST_WR_LO;
                            cyc_req_c = mk_req(1'b1, GB_REG_ROMB_LO, bank_in_c[7:0]);
                        end else if (need_hi_in_c) begin
                            state_d   = ST_WR_HI;
                            cyc_req_c = mk_req(1'b1, GB_REG_ROMB_HI, {7'b0, bank_in_c[8]});
                        end else begin
                            state_d   = ST_RD;
                            cyc_req_c = mk_req(1'b0, romx_addr(req_addr_i[OFFS_W-1:0]), 8'h00);
                        end
                    end else begin
                        state_d   = ST_RD;
                        cyc_req_c = mk_req(wr_d, req_addr_i[ADDR_W-1:0], req_wdata_i);
                    end
                end
            end
            ST_WR_LO: begin
                if (cyc_last_c) begin
                    cache_d.lo       = bank_q_c[7:0];
                    cache_d.lo_valid = 1'b1;
                    start_c          = 1'b1;
                    if (need_hi_q_c) begin
                        state_d   = ST_WR_HI;
                        cyc_req_c = mk_req(1'b1, GB_REG_ROMB_HI, {7'b0, bank_q_c[8]});
                    end else begin
                        state_d   = ST_RD;
                        cyc_req_c = mk_req(1'b0, romx_addr(addr_q[OFFS_W-1:0]), 8'h00);
                    end
                end
            end
            ST_WR_HI: begin
                if (cyc_last_c) begin
                    cache_d.hi       = bank_q_c[8];
                    cache_d.hi_valid = 1'b1;
                    start_c          = 1'b1;
                    state_d          = ST_RD;
                    cyc_req_c        = mk_req(1'b0, romx_addr(addr_q[OFFS_W-1:0]), 8'h00);
                end
            end
            // Final access; raw writes run here too and may hit the bank registers directly
            ST_RD: begin
                if (cyc_last_c && wr_q) begin
                    if (addr_q[15:12] == 4'h2) begin
                        cache_d.lo       = wdata_q;
                        cache_d.lo_valid = 1'b1;
                    end else if (addr_q[15:12] == 4'h3) begin
                        cache_d.hi       = wdata_q[0];
                        cache_d.hi_valid = 1'b1;
                    end
                end
                if (cyc_done) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = wr_q ? 8'h00 : cyc_rdata;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_gb_cart_bus_master.sv
// Bench for gb_cart_bus_master: bus-timing monitor plus response scoreboard
// driven from a reference model of the mapper bank cache.
module tb_gb_cart_bus_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [22:0] req_addr_i;
    logic [7:0]  req_wdata_i;
    logic        rsp_valid_o;
    logic [7:0]  rsp_data_o;
    logic [15:0] gb_addr_o;
    logic [7:0]  gb_dout_o;
    logic        gb_doe_o;
    logic [7:0]  gb_din_i;
    logic        gb_rd_n_o;
    logic        gb_wr_n_o;
    logic        gb_cs_n_o;

    logic [7:0]  din_seed = 8'h00;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    typedef struct {
        int         lat;
        logic [7:0] data;
    } rsp_t;
    rsp_t sb_q[$];

    logic [7:0] m_lo;
    logic       m_lov = 1'b0;
    logic       m_hi;
    logic       m_hiv = 1'b0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Cartridge model: data is a function of address, only while the read strobe is low
    assign gb_din_i = !gb_rd_n_o ? (gb_addr_o[7:0] ^ gb_addr_o[15:8] ^ din_seed) : 8'hFF;

    gb_cart_bus_master dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .gb_addr_o   (gb_addr_o),
        .gb_dout_o   (gb_dout_o),
        .gb_doe_o    (gb_doe_o),
        .gb_din_i    (gb_din_i),
        .gb_rd_n_o   (gb_rd_n_o),
        .gb_wr_n_o   (gb_wr_n_o),
        .gb_cs_n_o   (gb_cs_n_o)
    );

    task automatic run_cmd(input logic [1:0] op, input logic [22:0] addr,
                           input logic [7:0] wdata, input string name);
        logic [23:0] exp_w[$];
        logic [23:0] obs_w[$];
        logic [8:0]  bank;
        logic [15:0] rd_a;
        logic [15:0] obs_rd_a;
        logic        is_rd, got, overlap, unstable, prev_wr_n, ready_done;
        logic [7:0]  got_data;
        int          exp_cs, acc, rel, lat, wr_low, rd_low, doe_cnt, cs_cnt, first_lo;
        rsp_t        r;

        bank   = addr[22:14];
        is_rd  = 1'b1;
        rd_a   = addr[15:0];
        exp_cs = 0;
        if (op == 2'b10) begin
            if (!m_lov || m_lo != bank[7:0]) begin
                exp_w.push_back({16'h2000, bank[7:0]});
                m_lo = bank[7:0]; m_lov = 1'b1;
            end
            if (!m_hiv || m_hi != bank[8]) begin
                exp_w.push_back({16'h3000, 7'b0, bank[8]});
                m_hi = bank[8]; m_hiv = 1'b1;
            end
            rd_a = {2'b01, addr[13:0]};
        end else if (op == 2'b01) begin
            is_rd = 1'b0;
            exp_w.push_back({addr[15:0], wdata});
            if (addr[15:12] == 4'h2) begin m_lo = wdata; m_lov = 1'b1; end
            else if (addr[15:12] == 4'h3) begin m_hi = wdata[0]; m_hiv = 1'b1; end
        end
        if (op != 2'b10 && addr[15:0] >= 16'hA000 && addr[15:0] <= 16'hBFFF) exp_cs = 6;
        r.lat  = 1 + 8 * (exp_w.size() + (is_rd ? 1 : 0));
        r.data = is_rd ? (rd_a[7:0] ^ rd_a[15:8] ^ din_seed) : 8'h00;
        sb_q.push_back(r);

        for (int i = 0; i < 40 && req_ready_o !== 1'b1; i++) @(negedge clk_i);
        n_chk++;
        if (req_ready_o !== 1'b1) begin
            $display("FAIL %s ready_timeout got %b want 1", name, req_ready_o);
            void'(sb_q.pop_back());
            return;
        end
        n_pass++;

        req_valid_i = 1'b1; req_op_i = op; req_addr_i = addr; req_wdata_i = wdata;
        @(posedge clk_i);
        #1;
        acc = cyc;
        req_valid_i = 1'b0;
        req_op_i    = 2'($urandom);
        req_addr_i  = 23'($urandom);
        req_wdata_i = 8'($urandom);

        got = 1'b0; overlap = 1'b0; unstable = 1'b0; prev_wr_n = 1'b1; ready_done = 1'b1;
        wr_low = 0; rd_low = 0; doe_cnt = 0; cs_cnt = 0; first_lo = -1; lat = -1;
        obs_rd_a = 16'h0; got_data = 8'h00;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_i);
            rel = cyc - acc;
            if (!gb_rd_n_o && !gb_wr_n_o) overlap = 1'b1;
            if ((!gb_rd_n_o || !gb_wr_n_o) && first_lo < 0) first_lo = rel;
            if (!gb_wr_n_o) begin
                wr_low++;
                if (prev_wr_n) obs_w.push_back({gb_addr_o, gb_dout_o});
                else if (obs_w[$] !== {gb_addr_o, gb_dout_o}) unstable = 1'b1;
            end
            if (!gb_rd_n_o) begin rd_low++; obs_rd_a = gb_addr_o; end
            if (gb_doe_o) doe_cnt++;
            if (!gb_cs_n_o) cs_cnt++;
            prev_wr_n = gb_wr_n_o;
            if (rsp_valid_o) begin
                got = 1'b1; lat = rel; got_data = rsp_data_o; ready_done = req_ready_o;
            end
        end

        r = sb_q.pop_front();
        n_chk++; if (!got) $display("FAIL %s rsp_timeout got none want rsp at +%0d", name, r.lat); else n_pass++;
        n_chk++; if (lat !== r.lat) $display("FAIL %s latency got %0d want %0d", name, lat, r.lat); else n_pass++;
        n_chk++; if (got_data !== r.data) $display("FAIL %s rsp_data got %h want %h", name, got_data, r.data); else n_pass++;
        n_chk++; if (obs_w.size() !== exp_w.size()) $display("FAIL %s n_writes got %0d want %0d", name, obs_w.size(), exp_w.size()); else n_pass++;
        for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++) begin
            n_chk++; if (obs_w[k] !== exp_w[k]) $display("FAIL %s write%0d got %h want %h", name, k, obs_w[k], exp_w[k]); else n_pass++;
        end
        n_chk++; if (wr_low !== 4 * exp_w.size()) $display("FAIL %s wr_low_clks got %0d want %0d", name, wr_low, 4 * exp_w.size()); else n_pass++;
        n_chk++; if (doe_cnt !== 8 * exp_w.size()) $display("FAIL %s doe_clks got %0d want %0d", name, doe_cnt, 8 * exp_w.size()); else n_pass++;
        n_chk++; if (rd_low !== (is_rd ? 4 : 0)) $display("FAIL %s rd_low_clks got %0d want %0d", name, rd_low, is_rd ? 4 : 0); else n_pass++;
        if (is_rd) begin
            n_chk++; if (obs_rd_a !== rd_a) $display("FAIL %s rd_addr got %h want %h", name, obs_rd_a, rd_a); else n_pass++;
        end
        n_chk++; if (first_lo !== 2) $display("FAIL %s first_strobe got %0d want 2", name, first_lo); else n_pass++;
        n_chk++; if (overlap || unstable) $display("FAIL %s strobe_integrity got ovl=%b unst=%b want 0 0", name, overlap, unstable); else n_pass++;
        n_chk++; if (cs_cnt !== exp_cs) $display("FAIL %s cs_low_clks got %0d want %0d", name, cs_cnt, exp_cs); else n_pass++;
        n_chk++; if (ready_done !== 1'b0) $display("FAIL %s ready_in_done got %b want 0", name, ready_done); else n_pass++;
        @(negedge clk_i);
        n_chk++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) $display("FAIL %s after_done got rdy=%b vld=%b want 1 0", name, req_ready_o, rsp_valid_o); else n_pass++;
        n_chk++; if (rsp_data_o !== r.data) $display("FAIL %s rsp_hold got %h want %h", name, rsp_data_o, r.data); else n_pass++;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_valid_i = 1'b0; req_op_i = 2'b00; req_addr_i = '0; req_wdata_i = '0;
        repeat (2) @(negedge clk_i);
        n_chk++; if ({gb_rd_n_o, gb_wr_n_o, gb_cs_n_o} !== 3'b111) $display("FAIL reset strobes got %b want 111", {gb_rd_n_o, gb_wr_n_o, gb_cs_n_o}); else n_pass++;
        n_chk++; if (gb_doe_o !== 1'b0) $display("FAIL reset doe got %b want 0", gb_doe_o); else n_pass++;
        n_chk++; if (gb_addr_o !== 16'h0 || gb_dout_o !== 8'h0) $display("FAIL reset bus got %h/%h want 0000/00", gb_addr_o, gb_dout_o); else n_pass++;
        n_chk++; if (req_ready_o !== 1'b1) $display("FAIL reset ready got %b want 1", req_ready_o); else n_pass++;
        n_chk++; if (rsp_valid_o !== 1'b0 || rsp_data_o !== 8'h0) $display("FAIL reset rsp got %b/%h want 0/00", rsp_valid_o, rsp_data_o); else n_pass++;
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_raw_write();
        run_cmd(2'b01, 23'h000000, 8'h0A, "raw_wr_0000");
    endtask

    task automatic test_raw_read();
        din_seed = 8'h6D;
        run_cmd(2'b00, 23'h000150, 8'h00, "raw_rd_0150");
        run_cmd(2'b11, 23'h000777, 8'h00, "rsvd_op_rd");
    endtask

    task automatic test_linear();
        din_seed = 8'h21;
        run_cmd(2'b10, 23'h004123, 8'h00, "lin_bank1_cold");
    endtask

    task automatic test_bank_cache();
        run_cmd(2'b10, 23'h004123, 8'h00, "lin_bank1_hit");
        run_cmd(2'b10, {9'h101, 14'h0055}, 8'h00, "lin_bank101");
    endtask

    task automatic test_sram_and_raw_bank();
        din_seed = 8'h93;
        run_cmd(2'b00, 23'h00A010, 8'h00, "raw_rd_sram");
        run_cmd(2'b01, 23'h002000, 8'h55, "raw_wr_romb_lo");
        run_cmd(2'b10, {9'h055, 14'h3FFF}, 8'h00, "lin_bank055");
        run_cmd(2'b10, {9'h000, 14'h0001}, 8'h00, "lin_bank0");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            din_seed = 8'($urandom);
            run_cmd(2'($urandom), 23'($urandom), 8'($urandom), $sformatf("b2b%0d", i));
        end
    endtask

    task automatic test_rst_mid();
        int  acc;
        logic seen;
        for (int i = 0; i < 40 && req_ready_o !== 1'b1; i++) @(negedge clk_i);
        req_valid_i = 1'b1; req_op_i = 2'b01; req_addr_i = 23'h002000; req_wdata_i = 8'h01;
        @(posedge clk_i);
        #1;
        acc = cyc;
        req_valid_i = 1'b0;
        for (int i = 0; i < 10 && (cyc - acc) < 4; i++) @(negedge clk_i);
        n_chk++; if (gb_wr_n_o !== 1'b0) $display("FAIL rst_mid pre_strobe got %b want 0", gb_wr_n_o); else n_pass++;
        #2 rst_i = 1'b1;
        #1;
        n_chk++; if (gb_wr_n_o !== 1'b1 || gb_doe_o !== 1'b0) $display("FAIL rst_mid release got wr_n=%b doe=%b want 1 0", gb_wr_n_o, gb_doe_o); else n_pass++;
        n_chk++; if (req_ready_o !== 1'b1 || gb_addr_o !== 16'h0) $display("FAIL rst_mid state got rdy=%b addr=%h want 1 0000", req_ready_o, gb_addr_o); else n_pass++;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) seen = 1'b1;
        end
        n_chk++; if (seen !== 1'b0) $display("FAIL rst_mid stray_rsp got %b want 0", seen); else n_pass++;
        m_lov = 1'b0;
        m_hiv = 1'b0;
        din_seed = 8'h5A;
        run_cmd(2'b10, 23'h004123, 8'h00, "lin_after_rst");
    endtask

    initial begin
        test_reset();
        test_raw_write();
        test_raw_read();
        test_linear();
        test_bank_cache();
        test_sram_and_raw_bank();
        test_back_to_back();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
